// File: rtl/ram_2p.sv
// Two-port byte-writable RAM, one clock, with a clear sweep after reset.
// Define RAM_2P_OUTREG_EN to add an output register (read latency 2).
module ram_2p #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wEn,
    input  logic [ADDR_W-1:0]   wAddr,
    input  logic [DATA_W-1:0]   wDat,
    input  logic [DATA_W/8-1:0] wBe,
    input  logic                rEn,
    input  logic [ADDR_W-1:0]   rAddr,
    output logic [DATA_W-1:0]   rDat,
    output logic                rValid,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   rd_dat_q, rd_dat_d;
    logic                rd_vld_q, rd_vld_d;
    logic                rd_fire;

    // Next state: sweep one word per cycle, leave CLEAR after the last one
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = READY;
                end
            end
            READY: begin
                clr_cnt_d = clr_cnt_q;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // State and sweep counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage: zero fill while sweeping, byte-masked writes once ready
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR) begin
                mem_q[clr_cnt_q] <= '0;
            end else if (wEn) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (wBe[i]) begin
                        mem_q[wAddr][8*i +: 8] <= wDat[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read port next state; array read sees pre-write data (read-first)
    always_comb begin
        rd_fire  = (state_q == READY) && rEn;
        rd_vld_d = rd_fire;
        rd_dat_d = rd_dat_q;
        if (rd_fire) begin
            rd_dat_d = mem_q[rAddr];
        end
    end

    // First read stage: data holds between reads, valid pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_dat_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_dat_q <= rd_dat_d;
            rd_vld_q <= rd_vld_d;
        end
    end

`ifdef RAM_2P_OUTREG_EN
    logic [DATA_W-1:0] out_dat_q, out_dat_d;
    logic              out_vld_q;

    // Output stage only reloads data when a read completes
    always_comb begin
        out_dat_d = out_dat_q;
        if (rd_vld_q) begin
            out_dat_d = rd_dat_q;
        end
    end

    // Extra output pipeline register
    always_ff @(posedge clock) begin
        if (reset) begin
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
        end else begin
            out_dat_q <= out_dat_d;
            out_vld_q <= rd_vld_q;
        end
    end

    assign rDat   = out_dat_q;
    assign rValid = out_vld_q;
`else
    assign rDat   = rd_dat_q;
    assign rValid = rd_vld_q;
`endif

    assign busy = reset | (state_q == CLEAR);

endmodule

// File: doc/ram_2p.md
RAM_2P -- requirements
Module: ram_2p

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 9, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 SHALL have port clock  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wEn  input  1  write request.
REQ-006 SHALL have port wAddr  input  ADDR_W  write address.
REQ-007 SHALL have port wDat  input  DATA_W  write data.
REQ-008 SHALL have port wBe  input  DATA_W/8  byte enables; bit i covers wDat[8i+7:8i].
REQ-009 SHALL have port rEn  input  1  read request.
REQ-010 SHALL have port rAddr  input  ADDR_W  read address.
REQ-011 SHALL have port rDat  output  DATA_W  read data.
REQ-012 SHALL have port rValid  output  1  one-cycle pulse marking rDat valid.
REQ-013 SHALL have port busy  output  1  high while the post-reset clear sweep runs.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR (sweep) and READY.
REQ-015 In CLEAR, SHALL write all-zero to address clrCnt each cycle, incrementing clrCnt from 0 to DEPTH-1, then enter READY; the sweep takes exactly DEPTH cycles.
REQ-016 In CLEAR, SHALL ignore wEn and rEn; busy=1, rValid=0.
REQ-017 In READY, busy=0; SHALL accept independent write and read requests on every cycle.
REQ-018 On wEn in READY, SHALL update only bytes with wBe[i]=1 at wAddr; wBe=0 leaves memory unchanged.
REQ-019 On rEn in READY, SHALL present mem[rAddr] on rDat with rValid=1 exactly one cycle later (base latency 1).
REQ-020 Same-cycle wEn and rEn to the same address SHALL be read-first: rDat returns the pre-write contents.
REQ-021 Back-to-back reads SHALL be accepted every cycle; rValid stays high for consecutive reads.
REQ-022 rDat SHALL hold its last value when no read completes; rValid=0 on those cycles.
REQ-023 Addresses SHALL wrap naturally in ADDR_W bits; no out-of-range condition exists.

Reset
REQ-024 reset SHALL be sampled on the rising edge of clock only; no asynchronous path.
REQ-025 While reset=1, SHALL force rDat=0, rValid=0, busy=1, clrCnt=0, state=CLEAR.
REQ-026 Reset asserted mid-sweep or mid-read SHALL restart the sweep at address 0 and discard any in-flight read.
REQ-027 The first sweep write SHALL occur in the first cycle after reset deasserts.

Configuration
REQ-028 Macro RAM_2P_OUTREG_EN SHALL control an extra output pipeline register on rDat/rValid.
REQ-029 With RAM_2P_OUTREG_EN defined, read latency SHALL be 2 cycles; read-first rule, throughput and reset values unchanged.
REQ-030 Without RAM_2P_OUTREG_EN, read latency SHALL be 1 cycle as in REQ-019.

Verification
REQ-031 Reset 1 cycle, release -> busy=1 for exactly 512 cycles, then 0; read of addr 0x1FF -> rDat=0x00000000.
REQ-032 Write 0xDEADBEEF to 0x010 wBe=0xF, then read 0x010 -> rDat=0xDEADBEEF, rValid high exactly 1 cycle, 1 cycle after rEn.
REQ-033 Write 0x11223344 wBe=0x5 over 0xDEADBEEF at 0x010 -> read returns 0xDE22BE44.
REQ-034 Same cycle write 0xCAFEF00D and read at 0x020 holding 0x12345678 -> rDat=0x12345678; next read -> 0xCAFEF00D.
REQ-035 Reset asserted at sweep cycle 100 after writing nothing -> busy stays 1 for 512 cycles after release; rEn during sweep -> rValid stays 0.
REQ-036 With RAM_2P_OUTREG_EN, reads of 0x001,0x002,0x003 on consecutive cycles -> three consecutive rValid pulses starting 2 cycles after first rEn, data in order.
